// File: rtl/i2c_cmd_arbiter_if.sv
// Purpose : bundles the requester, I2C-engine and status signals of i2c_cmd_arbiter.
// Ports   : slave modport = the arbiter (takes requests/fin, drives acks/start/word/status);
//           master modport = the surrounding logic (requesters, engine, debug observer).
interface i2c_cmd_arbiter_if;
   logic        i_req0;
   logic [15:0] i_data0;
   logic        i_req1;
   logic [15:0] i_data1;
   logic        o_ack0;
   logic        o_ack1;
   logic        o_err;
   logic        o_i2c_start;
   logic [15:0] o_i2c_reg_data;
   logic        i_i2c_fin;
   logic        o_busy;
   logic [1:0]  o_state;

   modport slave (
      input  i_req0, i_data0, i_req1, i_data1, i_i2c_fin,
      output o_ack0, o_ack1, o_err, o_i2c_start, o_i2c_reg_data, o_busy, o_state
   );

   modport master (
      output i_req0, i_data0, i_req1, i_data1, i_i2c_fin,
      input  o_ack0, o_ack1, o_err, o_i2c_start, o_i2c_reg_data, o_busy, o_state
   );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Purpose : round-robin arbiter sharing one I2C engine between two command requesters.
// Latency : start pulse one cycle after the request is sampled; ack one cycle after engine fin.
// Backpressure: requests are level-held and wait while a transaction is owned.
// Ports   : i_clk, i_rst_n (async active-low) plain; everything else through bus (slave modport).
// Option  : define I2C_ARB_TIMEOUT_EN to compile in a WAIT watchdog of TIMEOUT_CYCLES cycles
//           that completes the transaction with o_err pulsed alongside the owner's ack.
module i2c_cmd_arbiter #(
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   i2c_cmd_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [15:0] data_q, data_d;
   logic        start_q, start_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic        win;

`ifdef I2C_ARB_TIMEOUT_EN
   logic [19:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Under contention the requester that was not served last wins; a lone request always wins.
   assign win = (bus.i_req0 && bus.i_req1) ? ~last_q : bus.i_req1;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      data_d  = data_q;
      start_d = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err_d   = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.i_req0 || bus.i_req1) begin
               owner_d = win;
               data_d  = win ? bus.i_data1 : bus.i_data0;
               start_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            // Ack is raised on the transition so it is high exactly during DONE.
            if (bus.i_i2c_fin) begin
               state_d = DONE;
               ack0_d  = ~owner_q;
               ack1_d  = owner_q;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_CYCLES - 20'd1) begin
               state_d = DONE;
               ack0_d  = ~owner_q;
               ack1_d  = owner_q;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + 20'd1;
            end
`endif
         end
         DONE: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         data_q  <= 16'h0000;
         start_q <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         data_q  <= data_d;
         start_q <= start_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign bus.o_i2c_start    = start_q;
   assign bus.o_i2c_reg_data = data_q;
   assign bus.o_ack0         = ack0_q;
   assign bus.o_ack1         = ack1_q;
   assign bus.o_err          = err_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_state        = state_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: expected transactions (owner, word, err) are queued when requests
// are raised and a monitor process checks every start pulse and ack against that queue.
module tb_i2c_cmd_arbiter;
   localparam logic [19:0] TO = 20'd16;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam logic TO_ERR = 1'b1;
`else
   localparam logic TO_ERR = 1'b0;
`endif

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   i2c_cmd_arbiter_if bus();
   i2c_cmd_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus.slave));

   logic        req0 = 1'b0, req1 = 1'b0;
   logic [15:0] data0 = '0, data1 = '0;
   logic        eng_fin = 1'b0, man_fin = 1'b0;
   logic        auto_fin = 1'b0, hold_both = 1'b0, scramble = 1'b0;
   assign bus.i_req0    = req0;
   assign bus.i_req1    = req1;
   assign bus.i_data0   = data0;
   assign bus.i_data1   = data1;
   assign bus.i_i2c_fin = eng_fin | man_fin;

   typedef struct {logic id; logic [15:0] data; logic err;} exp_t;
   exp_t exp_q[$];
   logic last_srv = 1'b1;   // reference model: requester served most recently
   int   n_cmp = 0, n_bad = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endfunction

   function automatic void push(logic id, logic [15:0] d, logic err);
      exp_t e;
      e.id = id; e.data = d; e.err = err;
      exp_q.push_back(e);
      last_srv = id;
   endfunction

   // Requester behaviour: drop the request once acked; optionally re-raise (continuous contention).
   task automatic tick();
      @(negedge i_clk);
      if (hold_both) begin req0 = 1'b1; req1 = 1'b1; end
      if (bus.o_ack0) req0 = 1'b0;
      if (bus.o_ack1) req1 = 1'b0;
      if (scramble && bus.o_i2c_start && exp_q.size() != 0) begin
         if (exp_q[0].id) data1 = 16'($urandom); else data0 = 16'($urandom);
      end
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      tick();
      while ((req0 || req1 || bus.o_busy) && n < 300) begin tick(); n++; end
      check({name, "_idle_reached"}, 32'(n < 300), 32'd1);
   endtask

   // I2C engine model: answers each start after a random delay, sometimes with a stray fin in ISSUE.
   initial begin
      int fin_cnt = 0;
      forever begin
         @(negedge i_clk);
         eng_fin = 1'b0;
         if (auto_fin && i_rst_n) begin
            if (fin_cnt > 0) begin
               fin_cnt--;
               if (fin_cnt == 0) eng_fin = 1'b1;
            end
            if (bus.o_i2c_start) begin
               fin_cnt = $urandom_range(1, 6);
               if ($urandom_range(0, 3) == 0) eng_fin = 1'b1;
            end
         end
      end
   end

   // Monitor: compares every start and ack with the head of the expectation queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (i_rst_n) begin
            if (bus.o_i2c_start) begin
               check("start_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) check("start_word", 32'(bus.o_i2c_reg_data), 32'(exp_q[0].data));
            end
            if (bus.o_ack0 || bus.o_ack1) begin
               check("single_ack", 32'(bus.o_ack0 & bus.o_ack1), 32'd0);
               check("ack_in_done", 32'(bus.o_state), 32'd3);
               check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("ack_owner", 32'(bus.o_ack1), 32'(e.id));
                  check("ack_err", 32'(bus.o_err), 32'(e.err));
                  check("ack_word", 32'(bus.o_i2c_reg_data), 32'(e.data));
               end
            end
         end
      end
   end

   initial begin
      int n, acks;
      logic first;
      logic err_seen;

      // Reset values
      repeat (3) tick();
      check("rst_state", 32'(bus.o_state), 32'd0);
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_start", 32'(bus.o_i2c_start), 32'd0);
      check("rst_ack0", 32'(bus.o_ack0), 32'd0);
      check("rst_ack1", 32'(bus.o_ack1), 32'd0);
      check("rst_err", 32'(bus.o_err), 32'd0);
      check("rst_word", 32'(bus.o_i2c_reg_data), 32'd0);
      i_rst_n = 1'b1;
      tick();

      // Contention right after reset, held for four transactions: order 0,1,0,1
      data0 = 16'($urandom); data1 = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
         first = (last_srv == 1'b1) ? 1'b0 : 1'b1;
         push(first, first ? data1 : data0, 1'b0);
      end
      auto_fin = 1'b1; hold_both = 1'b1; req0 = 1'b1; req1 = 1'b1;
      acks = 0; n = 0;
      while (acks < 4 && n < 500) begin
         tick(); n++;
         if (bus.o_ack0 || bus.o_ack1) acks++;
      end
      hold_both = 1'b0; req0 = 1'b0; req1 = 1'b0;
      check("fair_ack_count", 32'(acks), 32'd4);
      wait_idle("fair");

      // Single request, cycle-exact latency
      auto_fin = 1'b0;
      tick();
      data0 = 16'h1E00; push(1'b0, 16'h1E00, 1'b0); req0 = 1'b1;          // cycle 0
      tick();                                                             // cycle 1
      check("single_start", 32'(bus.o_i2c_start), 32'd1);
      check("single_word", 32'(bus.o_i2c_reg_data), 32'h1E00);
      check("single_issue_busy", 32'(bus.o_busy), 32'd1);
      repeat (8) tick();                                                  // cycle 9
      check("single_wait", 32'(bus.o_state), 32'd2);
      tick(); man_fin = 1'b1;                                             // cycle 10
      tick(); man_fin = 1'b0;                                             // cycle 11
      check("single_ack0", 32'(bus.o_ack0), 32'd1);
      tick();                                                             // cycle 12
      check("single_busy_low", 32'(bus.o_busy), 32'd0);
      check("single_ack0_low", 32'(bus.o_ack0), 32'd0);

      // Watchdog: no fin from the engine
      data1 = 16'($urandom); push(1'b1, data1, TO_ERR); req1 = 1'b1;
      n = 0;
      while (bus.o_state != 2'd2 && n < 10) begin tick(); n++; end
      n = 0; err_seen = 1'b0;
      while (bus.o_state == 2'd2 && n < 1000) begin
         tick(); n++;
         err_seen = err_seen | bus.o_err;
      end
`ifdef I2C_ARB_TIMEOUT_EN
      check("to_wait_cycles", 32'(n), 32'(TO));
      check("to_ack1", 32'(bus.o_ack1), 32'd1);
      check("to_err", 32'(bus.o_err), 32'd1);
`else
      check("to_still_wait", 32'(bus.o_state), 32'd2);
      check("to_no_err", 32'(err_seen), 32'd0);
      man_fin = 1'b1; tick(); man_fin = 1'b0;
`endif
      wait_idle("to");

      // Reset in the middle of WAIT
      data0 = 16'($urandom) | 16'h0001; push(1'b0, data0, 1'b0); req0 = 1'b1;
      repeat (4) tick();
      check("mr_in_wait", 32'(bus.o_state), 32'd2);
      #1 i_rst_n = 1'b0;
      #1;
      check("mr_state", 32'(bus.o_state), 32'd0);
      check("mr_busy", 32'(bus.o_busy), 32'd0);
      check("mr_word", 32'(bus.o_i2c_reg_data), 32'd0);
      check("mr_acks", 32'({bus.o_ack0, bus.o_ack1, bus.o_err, bus.o_i2c_start}), 32'd0);
      exp_q.delete(); last_srv = 1'b1; req0 = 1'b0;
      tick(); i_rst_n = 1'b1;
      repeat (20) tick();
      check("mr_idle_after", 32'(bus.o_state), 32'd0);
      auto_fin = 1'b1;
      data1 = 16'($urandom); push(1'b1, data1, 1'b0); req1 = 1'b1;
      wait_idle("mr_new");

      // Randomized traffic with stray fins in IDLE
      scramble = 1'b1;
      for (int it = 0; it < 40; it++) begin
         data0 = 16'($urandom); data1 = 16'($urandom);
         case ($urandom_range(0, 2))
            0: begin push(1'b0, data0, 1'b0); req0 = 1'b1; end
            1: begin push(1'b1, data1, 1'b0); req1 = 1'b1; end
            default: begin
               first = (last_srv == 1'b1) ? 1'b0 : 1'b1;
               push(first, first ? data1 : data0, 1'b0);
               push(~first, first ? data0 : data1, 1'b0);
               req0 = 1'b1; req1 = 1'b1;
            end
         endcase
         wait_idle("rand");
         if ($urandom_range(0, 1) == 1) begin
            man_fin = 1'b1; tick(); man_fin = 1'b0; tick();
            check("spurious_fin_idle", 32'(bus.o_state), 32'd0);
         end
      end
      scramble = 1'b0;
      repeat (5) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20'd1000000, the WAIT-state watchdog limit in i_clk cycles (used only when I2C_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have the following ports:
- i_clk  in  1  single system clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req0  in  1  requester 0 (init sequencer) transaction request, level.
- i_data0  in  16  requester 0 register/data word.
- i_req1  in  1  requester 1 (runtime volume/mute control) transaction request, level.
- i_data1  in  16  requester 1 register/data word.
- o_ack0  out  1  one-cycle pulse: requester 0 transaction complete.
- o_ack1  out  1  one-cycle pulse: requester 1 transaction complete.
- o_err  out  1  one-cycle pulse with the ack: transaction aborted by timeout.
- o_i2c_start  out  1  start pulse to the shared I2C engine.
- o_i2c_reg_data  out  16  word presented to the I2C engine.
- i_i2c_fin  in  1  engine completion pulse.
- o_busy  out  1  high while a transaction is owned.
- o_state  out  2  current state encoding, for debug.

Function
REQ-003 SHALL implement the states IDLE=0, ISSUE=1, WAIT=2, DONE=3, with o_state equal to the state register.
REQ-004 In IDLE with no request asserted, the block SHALL remain in IDLE.
REQ-005 In IDLE with any request asserted, the block SHALL select a winner, latch its data into o_i2c_reg_data, record the owner, and move to ISSUE on the next edge.
REQ-006 Arbitration SHALL be round-robin: when both requests are asserted, the requester not served last wins; a lone request always wins.
REQ-007 The last-served pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-008 In ISSUE, o_i2c_start SHALL be 1 for exactly one cycle, then the block SHALL move to WAIT.
- Latency: o_i2c_start is high in the cycle after the request is sampled.
REQ-009 In WAIT, i_i2c_fin=1 SHALL move the block to DONE.
REQ-010 i_i2c_fin SHALL be ignored in IDLE, ISSUE and DONE.
REQ-011 In DONE, the owner's ack SHALL pulse for one cycle, the last-served pointer SHALL update to the owner, and the block SHALL return to IDLE.
REQ-012 o_i2c_reg_data SHALL hold the latched word from ISSUE through DONE.
- Requesters' data changes after latch SHALL have no effect.
REQ-013 A requester SHALL deassert its request in the cycle after its ack.
- A request still high in IDLE after its ack is treated as a new transaction.
REQ-014 o_busy SHALL be 1 in ISSUE, WAIT and DONE, and 0 in IDLE.
REQ-015 Never more than one ack SHALL be high at a time.
- o_ack0 and o_ack1 SHALL never be high outside DONE.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 Asserting i_rst_n low SHALL, asynchronously and at any point (including mid-transaction), force:
- state IDLE;
- o_i2c_start=0, o_ack0=0, o_ack1=0, o_err=0, o_busy=0;
- o_i2c_reg_data=16'h0000, o_state=0;
- last-served=1, timeout counter=0.
REQ-018 After reset is released, a transaction interrupted by reset SHALL NOT be acked or resumed.

Configuration
REQ-019 With macro I2C_ARB_TIMEOUT_EN defined, the timeout watchdog SHALL be compiled in:
- a counter clears on entry to WAIT and increments each WAIT cycle;
- on reaching TIMEOUT_CYCLES without i_i2c_fin, the block SHALL go to DONE;
- in that case o_err pulses together with the owner's ack.
REQ-020 Without I2C_ARB_TIMEOUT_EN, no counter SHALL exist, o_err SHALL be tied to 0, and WAIT SHALL persist until i_i2c_fin.

Verification
REQ-021 Single request: i_req0=1 with i_data0=16'h1E00 at cycle 0 -> o_i2c_start=1 with o_i2c_reg_data=16'h1E00 at cycle 1; fin at cycle 10 -> o_ack0 pulse at cycle 11; o_busy=0 at cycle 12.
REQ-022 Contention after reset: i_req0 and i_req1 raised in the same cycle -> requester 0 served first; requester 1 (still requesting) served next; o_ack0 precedes o_ack1.
REQ-023 Fairness: both requests held continuously for 4 transactions -> ack order 0,1,0,1.
REQ-024 Spurious fin: i_i2c_fin pulsed in IDLE and in ISSUE -> no ack and no state change beyond the normal ISSUE->WAIT.
REQ-025 Timeout (macro defined, TIMEOUT_CYCLES=16): no fin -> DONE reached 16 WAIT cycles after entry, with o_ack1 and o_err high in the same cycle. Without the macro -> remains in WAIT for 1000 cycles, o_err=0.
REQ-026 Mid-transaction reset: i_rst_n pulsed low during WAIT -> all outputs at reset values immediately; no ack after release; a new request is served normally.
